// File: rtl/cve2_sleep_ctrl.sv
// cve2_sleep_ctrl: core clock-gating and sleep controller.
// Gathers maskable and unmaskable wake sources, waits out an idle hysteresis
// before gating the core clock, and holds the clock off for a stabilisation
// delay after a wake. Reports the wake cause and counts sleep cycles.

// Integrated clock gate: the enable is captured while the clock is low, so
// the gated clock never sees a truncated high phase.
module cve2_clock_gate (
  input  logic clk_i,
  input  logic en_i,
  input  logic scan_cg_en_i,
  output logic clk_o
);

  logic en_q;

  // Sample the enable on the falling edge, as the ICG latch would.
  always_ff @(negedge clk_i) begin
    en_q <= en_i | scan_cg_en_i;
  end

  assign clk_o = clk_i & en_q;

endmodule

module cve2_sleep_ctrl #(
  parameter int unsigned NumWakeSrc = 18,
  parameter int unsigned IdleHyst   = 0,
  parameter int unsigned WakeDelay  = 0,
  parameter int unsigned CntWidth   = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  test_en_i,
  input  logic                  fetch_enable_i,
  input  logic                  core_busy_i,
  input  logic [NumWakeSrc-1:0] wake_src_i,
  input  logic [NumWakeSrc-1:0] wake_mask_i,
  input  logic                  wake_nm_i,
  input  logic                  sleep_cnt_clr_i,
  output logic                  clk_o,
  output logic                  clk_en_o,
  output logic                  fetch_enable_o,
  output logic                  core_sleep_o,
  output logic [NumWakeSrc:0]   wake_cause_o,
  output logic [CntWidth-1:0]   sleep_cycles_o
);

  localparam int unsigned IdleW = (IdleHyst > 0) ? $clog2(IdleHyst + 1) : 1;
  localparam int unsigned WakeW = (WakeDelay > 1) ? $clog2(WakeDelay) : 1;
  localparam logic [IdleW-1:0] IdleMax  = IdleW'(IdleHyst);
  localparam logic [WakeW-1:0] WakeInit = WakeW'((WakeDelay > 0) ? WakeDelay - 1 : 0);

  typedef enum logic [1:0] {
    Off   = 2'd0,
    Run   = 2'd1,
    Sleep = 2'd2,
    Wake  = 2'd3
  } state_e;

  state_e                state;
  logic                  core_busy_q;
  logic                  fetch_enable_q;
  logic [IdleW-1:0]      idle_cnt;
  logic [WakeW-1:0]      wake_cnt;
  logic                  clk_en_q;
  logic                  sleep_q;
  logic [NumWakeSrc:0]   wake_cause_q;
  logic [CntWidth-1:0]   sleep_cnt;
  logic [NumWakeSrc-1:0] wake_masked;
  logic                  wake_any;
  logic                  idle;

  // Mask is applied combinationally so a mask change acts in the same cycle.
  assign wake_masked = wake_src_i & wake_mask_i;
  assign wake_any    = (|wake_masked) | wake_nm_i;
  assign idle        = ~core_busy_q & ~wake_any;

  // Busy comes from the gated domain; register it and latch fetch enable.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      core_busy_q    <= 1'b0;
      fetch_enable_q <= 1'b0;
    end else begin
      core_busy_q    <= core_busy_i;
      fetch_enable_q <= fetch_enable_q | fetch_enable_i;
    end
  end

  // Sleep FSM with registered clock-enable, sleep flag and wake cause.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state        <= Off;
      idle_cnt     <= '0;
      wake_cnt     <= '0;
      clk_en_q     <= 1'b0;
      sleep_q      <= 1'b0;
      wake_cause_q <= '0;
    end else begin
      case (state)
        Off: begin
          if (fetch_enable_q) begin
            state    <= Run;
            clk_en_q <= 1'b1;
            idle_cnt <= '0;
          end
        end
        Run: begin
          if (idle) begin
            if (idle_cnt == IdleMax) begin
              state    <= Sleep;
              clk_en_q <= 1'b0;
              sleep_q  <= 1'b1;
            end else begin
              idle_cnt <= idle_cnt + 1'b1;
            end
          end else begin
            idle_cnt <= '0;
          end
        end
        Sleep: begin
          if (wake_any) begin
            wake_cause_q <= {wake_nm_i, wake_masked};
            sleep_q      <= 1'b0;
            if (WakeDelay == 0) begin
              state    <= Run;
              clk_en_q <= 1'b1;
              idle_cnt <= '0;
            end else begin
              state    <= Wake;
              wake_cnt <= WakeInit;
            end
          end
        end
        Wake: begin
          // Once started, a wake runs to completion even if the source drops.
          if (wake_cnt == '0) begin
            state    <= Run;
            clk_en_q <= 1'b1;
            idle_cnt <= '0;
          end else begin
            wake_cnt <= wake_cnt - 1'b1;
          end
        end
        default: begin
          state    <= Off;
          clk_en_q <= 1'b0;
          sleep_q  <= 1'b0;
        end
      endcase
    end
  end

  // Saturating count of cycles spent with the core clock off after sleeping.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sleep_cnt <= '0;
    end else if (sleep_cnt_clr_i) begin
      sleep_cnt <= '0;
    end else if ((state == Sleep || state == Wake) && (sleep_cnt != '1)) begin
      sleep_cnt <= sleep_cnt + 1'b1;
    end
  end

  assign clk_en_o       = clk_en_q;
  assign fetch_enable_o = fetch_enable_q;
  assign core_sleep_o   = sleep_q;
  assign wake_cause_o   = wake_cause_q;
  assign sleep_cycles_o = sleep_cnt;

  cve2_clock_gate u_clock_gate (
    .clk_i        (clk_i),
    .en_i         (clk_en_q),
    .scan_cg_en_i (test_en_i),
    .clk_o        (clk_o)
  );

endmodule

// File: tb/tb_cve2_sleep_ctrl.sv
// Testbench for cve2_sleep_ctrl: directed scenarios followed by random
// stimulus, all compared against a cycle-level behavioural model.
module tb_cve2_sleep_ctrl;

  localparam int NSRC  = 4;
  localparam int IHYST = 3;
  localparam int WDLY  = 2;
  localparam int CW    = 4;
  localparam int CMAX  = (1 << CW) - 1;

  logic            clk;
  logic            rst_ni;
  logic            test_en;
  logic            fetch_in;
  logic            busy_in;
  logic [NSRC-1:0] src_in;
  logic [NSRC-1:0] mask_in;
  logic            nm_in;
  logic            clr_in;
  logic            clk_o;
  logic            clk_en_o;
  logic            fetch_enable_o;
  logic            core_sleep_o;
  logic [NSRC:0]   wake_cause_o;
  logic [CW-1:0]   sleep_cycles_o;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model: what the outputs should read during the current cycle.
  logic          m_fe;
  logic          m_busy_q;
  logic          m_started;
  logic          m_on;
  logic          m_sleep;
  int            m_wait;
  int            m_quiet;
  int            m_cnt;
  logic [NSRC:0] m_cause;
  logic          prev_on;

  cve2_sleep_ctrl #(
    .NumWakeSrc (NSRC),
    .IdleHyst   (IHYST),
    .WakeDelay  (WDLY),
    .CntWidth   (CW)
  ) dut (
    .clk_i           (clk),
    .rst_ni          (rst_ni),
    .test_en_i       (test_en),
    .fetch_enable_i  (fetch_in),
    .core_busy_i     (busy_in),
    .wake_src_i      (src_in),
    .wake_mask_i     (mask_in),
    .wake_nm_i       (nm_in),
    .sleep_cnt_clr_i (clr_in),
    .clk_o           (clk_o),
    .clk_en_o        (clk_en_o),
    .fetch_enable_o  (fetch_enable_o),
    .core_sleep_o    (core_sleep_o),
    .wake_cause_o    (wake_cause_o),
    .sleep_cycles_o  (sleep_cycles_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_fe      = 1'b0;
    m_busy_q  = 1'b0;
    m_started = 1'b0;
    m_on      = 1'b0;
    m_sleep   = 1'b0;
    m_wait    = 0;
    m_quiet   = 0;
    m_cnt     = 0;
    m_cause   = '0;
    prev_on   = 1'b0;
  endtask

  // Advance the model across one rising edge using the inputs now applied.
  task automatic model_update();
    logic wake;
    logic idle_now;
    logic resting;
    wake     = ((src_in & mask_in) != '0) || nm_in;
    idle_now = !m_busy_q && !wake;
    resting  = m_started && !m_on;
    if (clr_in) m_cnt = 0;
    else if (resting) m_cnt = (m_cnt >= CMAX) ? CMAX : m_cnt + 1;
    if (!m_started) begin
      if (m_fe) begin
        m_started = 1'b1;
        m_on      = 1'b1;
        m_quiet   = 0;
      end
    end else if (m_on) begin
      if (idle_now) begin
        if (m_quiet == IHYST) begin
          m_on    = 1'b0;
          m_sleep = 1'b1;
        end else begin
          m_quiet++;
        end
      end else begin
        m_quiet = 0;
      end
    end else if (m_sleep) begin
      if (wake) begin
        m_cause = {nm_in, src_in & mask_in};
        m_sleep = 1'b0;
        m_wait  = WDLY;
        if (m_wait == 0) begin
          m_on    = 1'b1;
          m_quiet = 0;
        end
      end
    end else begin
      m_wait--;
      if (m_wait <= 0) begin
        m_on    = 1'b1;
        m_quiet = 0;
      end
    end
    m_fe     = m_fe | fetch_in;
    m_busy_q = busy_in;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".clk_en"}, 32'(clk_en_o), 32'(m_on));
    chk({tag, ".fetch_en"}, 32'(fetch_enable_o), 32'(m_fe));
    chk({tag, ".sleep"}, 32'(core_sleep_o), 32'(m_sleep));
    chk({tag, ".cause"}, 32'(wake_cause_o), 32'(m_cause));
    chk({tag, ".cycles"}, 32'(sleep_cycles_o), 32'(m_cnt));
  endtask

  // One clock cycle: called just after a falling edge, returns just after the next.
  task automatic step(input logic fe, input logic busy, input logic [NSRC-1:0] src,
                      input logic [NSRC-1:0] mask, input logic nm, input logic clr);
    fetch_in = fe;
    busy_in  = busy;
    src_in   = src;
    mask_in  = mask;
    nm_in    = nm;
    clr_in   = clr;
    prev_on  = m_on;
    model_update();
    @(posedge clk);
    #1;
    chk("clk_o_high_phase", 32'(clk_o), 32'(prev_on));
    @(negedge clk);
    check_all("cyc");
  endtask

  initial begin
    logic bsy;
    logic [NSRC-1:0] rs;
    test_en  = 1'b0;
    fetch_in = 1'b0;
    busy_in  = 1'b0;
    src_in   = '0;
    mask_in  = '0;
    nm_in    = 1'b0;
    clr_in   = 1'b0;
    rst_ni   = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_all("reset");
    @(posedge clk);
    #1;
    chk("reset_clk_o", 32'(clk_o), 32'd0);
    @(negedge clk);
    rst_ni = 1'b1;

    // Stays off without fetch enable, then a one-cycle fetch pulse.
    repeat (4) step(1'b0, 1'b1, 4'h0, 4'hF, 1'b0, 1'b0);
    chk("off_clk_en", 32'(clk_en_o), 32'd0);
    step(1'b1, 1'b1, 4'h0, 4'hF, 1'b0, 1'b0);
    chk("fetch_t1", 32'(fetch_enable_o), 32'd1);
    chk("clk_en_t1", 32'(clk_en_o), 32'd0);
    step(1'b0, 1'b1, 4'h0, 4'hF, 1'b0, 1'b0);
    chk("clk_en_t2", 32'(clk_en_o), 32'd1);
    repeat (10) step(1'b0, 1'b1, 4'h0, 4'hF, 1'b0, 1'b0);

    // Busy drops: gating after the hysteresis.
    repeat (4) step(1'b0, 1'b0, 4'h0, 4'hF, 1'b0, 1'b0);
    chk("pre_gate_clk_en", 32'(clk_en_o), 32'd1);
    step(1'b0, 1'b0, 4'h0, 4'hF, 1'b0, 1'b0);
    chk("gate_clk_en", 32'(clk_en_o), 32'd0);
    chk("gate_sleep", 32'(core_sleep_o), 32'd1);
    repeat (6) step(1'b0, 1'b0, 4'h0, 4'hF, 1'b0, 1'b0);
    chk("sleep_cycles6", 32'(sleep_cycles_o), 32'd6);

    // Masked source pulse wakes; busy during wake is ignored.
    step(1'b0, 1'b1, 4'b0100, 4'hF, 1'b0, 1'b0);
    chk("wake_sleep_low", 32'(core_sleep_o), 32'd0);
    chk("wake_clk_en_t1", 32'(clk_en_o), 32'd0);
    step(1'b0, 1'b1, 4'h0, 4'hF, 1'b0, 1'b0);
    chk("wake_clk_en_t2", 32'(clk_en_o), 32'd0);
    step(1'b0, 1'b1, 4'h0, 4'hF, 1'b0, 1'b0);
    chk("wake_clk_en_t3", 32'(clk_en_o), 32'd1);
    chk("wake_cause_src2", 32'(wake_cause_o), 32'h04);

    // All sources masked off: stays asleep until the unmaskable wake.
    repeat (9) step(1'b0, 1'b0, 4'hF, 4'h0, 1'b0, 1'b0);
    chk("masked_sleep", 32'(core_sleep_o), 32'd1);
    chk("masked_cause_held", 32'(wake_cause_o), 32'h04);
    step(1'b0, 1'b0, 4'hF, 4'h0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 4'h0, 4'h0, 1'b0, 1'b0);
    chk("nm_clk_en_t3", 32'(clk_en_o), 32'd1);
    chk("nm_cause", 32'(wake_cause_o), 32'h10);

    // Short idle burst and an enabled source during idle: no gating.
    repeat (3) step(1'b0, 1'b1, 4'h0, 4'hF, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 4'h0, 4'hF, 1'b0, 1'b0);
      chk("short_idle_clk_en", 32'(clk_en_o), 32'd1);
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 4'h0, 4'hF, 1'b0, 1'b0);
      chk("busy_again_clk_en", 32'(clk_en_o), 32'd1);
    end
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b0, 4'b0001, 4'b0001, 1'b0, 1'b0);
      chk("src_hold_clk_en", 32'(clk_en_o), 32'd1);
    end

    // Saturation of the sleep counter and its clear.
    repeat (5) step(1'b0, 1'b0, 4'h0, 4'hF, 1'b0, 1'b0);
    step(1'b0, 1'b0, 4'h0, 4'hF, 1'b0, 1'b1);
    chk("cnt_cleared", 32'(sleep_cycles_o), 32'd0);
    repeat (20) step(1'b0, 1'b0, 4'h0, 4'hF, 1'b0, 1'b0);
    chk("cnt_saturated", 32'(sleep_cycles_o), 32'hF);
    step(1'b0, 1'b0, 4'h0, 4'hF, 1'b0, 1'b1);
    chk("cnt_clr_sat", 32'(sleep_cycles_o), 32'd0);

    // Asynchronous reset in the middle of a wake.
    step(1'b0, 1'b0, 4'h0, 4'hF, 1'b1, 1'b0);
    chk("in_wake_sleep", 32'(core_sleep_o), 32'd0);
    #2;
    rst_ni = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    chk("async_rst_clk_en", 32'(clk_en_o), 32'd0);
    chk("async_rst_fetch", 32'(fetch_enable_o), 32'd0);
    @(negedge clk);
    rst_ni = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1, 4'h0, 4'hF, 1'b0, 1'b0);
      chk("post_rst_off", 32'(clk_en_o), 32'd0);
    end
    step(1'b1, 1'b1, 4'h0, 4'hF, 1'b0, 1'b0);
    step(1'b0, 1'b1, 4'h0, 4'hF, 1'b0, 1'b0);
    chk("refetch_clk_en", 32'(clk_en_o), 32'd1);

    // Random traffic against the model.
    bsy = 1'b1;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(5) == 0) bsy = ~bsy;
      rs = ($urandom_range(9) == 0) ? NSRC'($urandom) : '0;
      step(($urandom_range(49) == 0), bsy, rs, NSRC'($urandom),
           ($urandom_range(39) == 0), ($urandom_range(59) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
